adc_bit_clk_align: RTL and testbench
====================================

# adc_bit_clk_align

Bit-clock alignment stage directly upstream of the ADC frame aligner. It sweeps the IDELAY tap of the LVDS bit clock (DCO) while the clock samples itself through a 1:8 ISERDES. It locks the tap at the first clock-edge transition, then asserts `BitClkDone`, which releases the frame aligner and data-lane logic. It runs entirely in the divided clock domain and owns the delay-line control for the bit-clock path only.

## Interface
Parameters:
- `TapBits`, 5: width of IDELAY tap value; last tap is 2^TapBits-1.
- `WordBits`, 8: width of the self-sampled clock word from the ISERDES.
- `SettleCycles`, 16: cycles waited after each tap load before sampling (≥1).
- `SampleCount`, 4: consecutive words compared per tap (≥2).

Ports:
- `BitClkDiv`  in  1  divided bit clock; all logic on its rising edge.
- `BitRstN`  in  1  asynchronous, active-low reset.
- `DlyRdy`  in  1  IDELAYCTRL ready; calibration runs only while high.
- `Restart`  in  1  single-cycle request to restart calibration from tap 0.
- `SmplWord`  in  WordBits  ISERDES output of DCO sampled by delayed DCO.
- `DlyTap`  out  TapBits  tap value for IDELAY VAR_LOAD.
- `DlyLoad`  out  1  one-cycle load strobe for `DlyTap`.
- `BitClkDone`  out  1  alignment locked; `DlyTap` holds the edge tap.
- `AlignFail`  out  1  sweep exhausted without finding an edge.

## Operation
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, DONE, FAIL.
- IDLE: tap=0, reference value invalid. Go to LOAD when `DlyRdy`=1.
- LOAD: `DlyLoad`=1 for exactly this cycle with the current `DlyTap`. Go to SETTLE.
- SETTLE: count `SettleCycles` cycles, then go to SAMPLE.
- SAMPLE: capture `SampleCount` consecutive `SmplWord` values. A tap is *stable* when all captured words are identical and equal all-zeros or all-ones. The stable value is bit 0. Go to EVAL.
- EVAL, one cycle:
  - Unstable: advance the tap.
  - Stable with no reference yet: latch reference = value, then advance the tap.
  - Stable and equal to the reference: advance the tap.
  - Stable and different from the reference: go to DONE with `DlyTap` unchanged.
- Advance: if `DlyTap` is the last tap, go to FAIL. Otherwise increment `DlyTap` and go to LOAD.
- DONE: `BitClkDone`=1, held until restart, reset, or loss of `DlyRdy`.
- FAIL: `AlignFail`=1, `BitClkDone`=0, `DlyTap` holds the last tap. Only `Restart` exits this state.
- `Restart`=1 in any state, or `DlyRdy`=0 in any state other than IDLE:
  - next state IDLE; `BitClkDone`, `AlignFail` and reference cleared; `DlyTap`=0.
  - No `DlyLoad` is issued until the next LOAD.
- When `Restart` and an EVAL decision occur in the same cycle, `Restart` wins.

## Timing
- Reset values: `DlyTap`=0, `DlyLoad`=0, `BitClkDone`=0, `AlignFail`=0, state IDLE.
- All outputs are registered; no combinational input-to-output path.
- Per-tap cost: T = 1 + SettleCycles + SampleCount + 1 = 22 cycles with defaults.
- `BitClkDone` rises the cycle after EVAL of the edge tap k: (k+1)·T cycles after the first LOAD cycle.
- `AlignFail` rises the cycle after EVAL of the last tap: 2^TapBits·T cycles after the first LOAD.
- `DlyLoad` pulses exactly once per evaluated tap. The pulse and its `DlyTap` value are valid in the same cycle.

## Structure
- Shared package `adc_lvds_pkg`:
  - state enum `bit_align_state_t`
  - default constants `ADC_TAP_BITS`=5 and `ADC_SERDES_WORD`=8, reused by the frame and data-lane stages.
- One sub-module, `adc_word_stable_check`. It takes a start strobe and `SmplWord`, counts `SampleCount` words, and returns `done`, `stable` and `value`. The top level holds the FSM, tap counter, settle counter and reference register.

## Test plan
- DCO model with edge at tap 9 (words 0x00 for taps 0–8, 0xFF from tap 9) → `BitClkDone` at 220 cycles after the first LOAD, `DlyTap`=9, 10 `DlyLoad` pulses.
- Jitter zone at taps 5–7 (alternating 0x0F/0xF0), 0x00 at taps 0–4, 0xFF from tap 8 → taps 5–7 unstable; lock at `DlyTap`=8.
- Unstable at tap 0, 0xFF at taps 1–3, 0x00 from tap 4 → reference taken at tap 1; lock at `DlyTap`=4.
- Constant 0xFF at all taps → `AlignFail`=1 after 704 cycles, `DlyTap`=31, `BitClkDone`=0; a `Restart` pulse clears `AlignFail` and `DlyTap`=0 next cycle.
- `DlyRdy` low during SETTLE of tap 3, or `BitRstN` asserted in DONE → next cycle IDLE with all outputs at reset values. When `DlyRdy` returns, the sweep restarts at tap 0 with a fresh reference.

Source files
------------

// File: rtl/adc_lvds_pkg.sv
// Shared types and defaults for the ADC LVDS capture path.
// Used by the bit-clock, frame and data-lane stages.
package adc_lvds_pkg;

  localparam int ADC_TAP_BITS    = 5;
  localparam int ADC_SERDES_WORD = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SAMPLE,
    EVAL,
    DONE,
    FAIL
  } bit_align_state_t;

endpackage

// File: rtl/adc_word_stable_check.sv
// Captures a burst of self-sampled clock words and reports whether
// they were all identical and uniform (all-zeros or all-ones).
module adc_word_stable_check
  import adc_lvds_pkg::*;
#(
  parameter int WordBits    = ADC_SERDES_WORD,
  parameter int SampleCount = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WordBits-1:0] SmplWord,
  output logic                done,
  output logic                stable,
  output logic                value
);

  localparam int CntW = $clog2(SampleCount);
  localparam logic [CntW-1:0] LastIdx =
    CntW'(SampleCount - 1);

  logic                busy;
  logic [CntW-1:0]     cnt;
  logic [WordBits-1:0] first;
  logic                same;
  logic                match;
  logic                uniform;

  assign match   = (SmplWord == first);
  assign uniform = (first == '0) || (first == '1);

  // Word capture: first word is the reference, later words compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      first  <= '0;
      same   <= 1'b0;
      done   <= 1'b0;
      stable <= 1'b0;
      value  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == '0) begin
          first <= SmplWord;
          same  <= 1'b1;
        end else begin
          same <= same & match;
        end
        if (cnt == LastIdx) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          stable <= same & match & uniform;
          value  <= first[0];
        end
      end
    end
  end

endmodule

// File: rtl/adc_bit_clk_align.sv
// Bit-clock alignment: sweeps the DCO IDELAY tap until the
// self-sampled clock flips level, then locks on that tap.
module adc_bit_clk_align
  import adc_lvds_pkg::*;
#(
  parameter int TapBits      = ADC_TAP_BITS,
  parameter int WordBits     = ADC_SERDES_WORD,
  parameter int SettleCycles = 16,
  parameter int SampleCount  = 4
) (
  input  logic                BitClkDiv,
  input  logic                BitRstN,
  input  logic                DlyRdy,
  input  logic                Restart,
  input  logic [WordBits-1:0] SmplWord,
  output logic [TapBits-1:0]  DlyTap,
  output logic                DlyLoad,
  output logic                BitClkDone,
  output logic                AlignFail
);

  localparam int CntMax =
    (SettleCycles > SampleCount) ? SettleCycles : SampleCount;
  localparam int CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] SettleLast =
    CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] SampleLast =
    CntW'(SampleCount - 1);
  localparam logic [TapBits-1:0] LastTap = '1;

  bit_align_state_t state;
  bit_align_state_t stateNext;

  logic [CntW-1:0]    cnt;
  logic [CntW-1:0]    cntNext;
  logic [TapBits-1:0] tapNext;
  logic               refValid;
  logic               refValidNext;
  logic               refVal;
  logic               refValNext;
  logic               abort;

  logic chkStart;
  logic chkDone;
  logic chkStable;
  logic chkValue;

  // FAIL is left only by an explicit restart request.
  assign abort = Restart ||
    (!DlyRdy && (state != IDLE) && (state != FAIL));

  assign chkStart = (state == SETTLE) && (cnt == SettleLast);

  adc_word_stable_check #(
    .WordBits    (WordBits),
    .SampleCount (SampleCount)
  ) u_check (
    .clk      (BitClkDiv),
    .rst_n    (BitRstN),
    .start    (chkStart),
    .SmplWord (SmplWord),
    .done     (chkDone),
    .stable   (chkStable),
    .value    (chkValue)
  );

  // State, counters, reference and registered outputs.
  always_ff @(posedge BitClkDiv or negedge BitRstN) begin
    if (!BitRstN) begin
      state      <= IDLE;
      cnt        <= '0;
      refValid   <= 1'b0;
      refVal     <= 1'b0;
      DlyTap     <= '0;
      DlyLoad    <= 1'b0;
      BitClkDone <= 1'b0;
      AlignFail  <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      refValid   <= refValidNext;
      refVal     <= refValNext;
      DlyTap     <= tapNext;
      DlyLoad    <= (stateNext == LOAD);
      BitClkDone <= (stateNext == DONE);
      AlignFail  <= (stateNext == FAIL);
    end
  end

  // Next-state, tap advance and reference latch.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    tapNext      = DlyTap;
    refValidNext = refValid;
    refValNext   = refVal;

    unique case (state)
      IDLE: begin
        tapNext      = '0;
        refValidNext = 1'b0;
        if (DlyRdy) stateNext = LOAD;
      end
      LOAD: begin
        cntNext   = '0;
        stateNext = SETTLE;
      end
      SETTLE: begin
        if (cnt == SettleLast) begin
          cntNext   = '0;
          stateNext = SAMPLE;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      SAMPLE: begin
        if (cnt == SampleLast) begin
          cntNext   = '0;
          stateNext = EVAL;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      EVAL: begin
        if (chkDone) begin
          if (chkStable && refValid &&
              (chkValue != refVal)) begin
            stateNext = DONE;
          end else begin
            if (chkStable && !refValid) begin
              refValidNext = 1'b1;
              refValNext   = chkValue;
            end
            if (DlyTap == LastTap) begin
              stateNext = FAIL;
            end else begin
              tapNext   = DlyTap + 1'b1;
              stateNext = LOAD;
            end
          end
        end
      end
      DONE: stateNext = DONE;
      FAIL: stateNext = FAIL;
      default: stateNext = IDLE;
    endcase

    if (abort) begin
      stateNext    = IDLE;
      cntNext      = '0;
      tapNext      = '0;
      refValidNext = 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_bit_clk_align.sv
// Bench for adc_bit_clk_align: DCO self-sample model per tap,
// sweep outcome checked against a tap-list reference model.
module tb_adc_bit_clk_align;

  localparam int TB = 5;
  localparam int WB = 8;
  localparam int SC = 16;
  localparam int SN = 4;
  localparam int T  = 1 + SC + SN + 1;
  localparam int NT = 1 << TB;

  localparam int P_ZERO  = 0;
  localparam int P_ONE   = 1;
  localparam int P_ALT   = 2;
  localparam int P_ODD   = 3;
  localparam int P_NOISE = 4;

  logic          BitClkDiv = 1'b0;
  logic          BitRstN   = 1'b0;
  logic          DlyRdy    = 1'b0;
  logic          Restart   = 1'b0;
  logic [WB-1:0] SmplWord  = '0;
  logic [TB-1:0] DlyTap;
  logic          DlyLoad;
  logic          BitClkDone;
  logic          AlignFail;

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;
  int loadedTap = 0;
  int pat [NT];

  adc_bit_clk_align #(
    .TapBits      (TB),
    .WordBits     (WB),
    .SettleCycles (SC),
    .SampleCount  (SN)
  ) dut (
    .BitClkDiv  (BitClkDiv),
    .BitRstN    (BitRstN),
    .DlyRdy     (DlyRdy),
    .Restart    (Restart),
    .SmplWord   (SmplWord),
    .DlyTap     (DlyTap),
    .DlyLoad    (DlyLoad),
    .BitClkDone (BitClkDone),
    .AlignFail  (AlignFail)
  );

  always #5 BitClkDiv = ~BitClkDiv;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [WB-1:0] wordFor(int code, int c);
    logic [WB-1:0] w;
    case (code)
      P_ZERO: w = 8'h00;
      P_ONE:  w = 8'hFF;
      P_ALT:  w = (c % 2 != 0) ? 8'h0F : 8'hF0;
      P_ODD:  w = 8'h55;
      default: begin
        w = 8'($urandom);
        if (w == 8'h00 || w == 8'hFF) w = 8'h3C;
      end
    endcase
    return w;
  endfunction

  task automatic step();
    @(posedge BitClkDiv);
    #1;
    cyc++;
    if (DlyLoad) loadedTap = int'(DlyTap);
    SmplWord = wordFor(pat[loadedTap], cyc);
  endtask

  task automatic fill(int lo, int hi, int code);
    for (int t = lo; t <= hi; t++) pat[t] = code;
  endtask

  function automatic int modelLock();
    bit haveRef = 1'b0;
    bit refV    = 1'b0;
    bit v;
    for (int t = 0; t < NT; t++) begin
      if (pat[t] == P_ZERO || pat[t] == P_ONE) begin
        v = (pat[t] == P_ONE);
        if (!haveRef) begin
          haveRef = 1'b1;
          refV    = v;
        end else if (v != refV) begin
          return t;
        end
      end
    end
    return -1;
  endfunction

  task automatic chkIdleOuts(string tag);
    chk({tag, "_tap"},  DlyTap,     0);
    chk({tag, "_load"}, DlyLoad,    0);
    chk({tag, "_done"}, BitClkDone, 0);
    chk({tag, "_fail"}, AlignFail,  0);
  endtask

  task automatic runSweep(string tag);
    int lock;
    int first;
    int loads;
    int seqErr;
    int endCyc;
    int expLoads;
    lock   = modelLock();
    first  = -1;
    loads  = 0;
    seqErr = 0;
    endCyc = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      step();
      if (DlyLoad) begin
        first = cyc;
        loads = 1;
        if (DlyTap != 0) seqErr++;
      end
    end
    chk({tag, "_start"}, first >= 0, 1);
    if (first >= 0) begin
      for (int i = 0; i < NT * T + 20 && endCyc < 0; i++) begin
        step();
        if (DlyLoad) begin
          if (int'(DlyTap) != loads) seqErr++;
          loads++;
        end
        if (BitClkDone || AlignFail) endCyc = cyc;
      end
    end
    expLoads = (lock < 0) ? NT : lock + 1;
    chk({tag, "_done"}, BitClkDone, lock >= 0);
    chk({tag, "_fail"}, AlignFail, lock < 0);
    chk({tag, "_tap"}, DlyTap, (lock < 0) ? NT - 1 : lock);
    chk({tag, "_lat"}, endCyc - first, expLoads * T);
    chk({tag, "_loads"}, loads, expLoads);
    chk({tag, "_seq"}, seqErr, 0);
  endtask

  task automatic pulseRestart(string tag);
    Restart = 1'b1;
    step();
    Restart = 1'b0;
    chkIdleOuts(tag);
  endtask

  task automatic randPat();
    int e;
    int b;
    e = $urandom_range(0, 40);
    b = $urandom_range(0, 1);
    for (int t = 0; t < NT; t++) begin
      if ($urandom_range(0, 9) < 3)
        pat[t] = P_ALT + $urandom_range(0, 2);
      else if ((t < e) == (b == 1))
        pat[t] = P_ONE;
      else
        pat[t] = P_ZERO;
    end
  endtask

  initial begin
    int seen;
    fill(0, NT - 1, P_ZERO);
    repeat (3) step();
    chkIdleOuts("reset");
    BitRstN = 1'b1;
    repeat (3) step();
    chkIdleOuts("noRdy");
    DlyRdy = 1'b1;

    // Edge at tap 9.
    fill(0, 8, P_ZERO);
    fill(9, NT - 1, P_ONE);
    runSweep("edge9");
    repeat (5) step();
    chk("hold_done", BitClkDone, 1);
    chk("hold_tap", DlyTap, 9);
    chk("hold_load", DlyLoad, 0);

    // Asynchronous reset while locked.
    @(negedge BitClkDiv);
    BitRstN = 1'b0;
    #1;
    chkIdleOuts("rstDone");
    step();
    BitRstN = 1'b1;
    fill(0, 2, P_NOISE);
    fill(3, 6, P_ONE);
    fill(7, NT - 1, P_ZERO);
    runSweep("afterRst");

    // Jitter zone at taps 5..7.
    fill(0, 4, P_ZERO);
    fill(5, 7, P_ALT);
    fill(8, NT - 1, P_ONE);
    pulseRestart("rs1");
    runSweep("jitter");

    // Unstable tap 0, reference taken at tap 1.
    fill(0, 0, P_NOISE);
    fill(1, 3, P_ONE);
    fill(4, NT - 1, P_ZERO);
    pulseRestart("rs2");
    runSweep("unst0");

    // No edge anywhere.
    fill(0, NT - 1, P_ONE);
    pulseRestart("rs3");
    runSweep("allOne");
    pulseRestart("failClr");

    // DlyRdy drop during SETTLE of tap 3.
    fill(0, 2, P_ONE);
    fill(3, NT - 1, P_ZERO);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      step();
      if (DlyLoad && DlyTap == 3) seen = 1;
    end
    chk("rdy_reach3", seen, 1);
    repeat (3) step();
    DlyRdy = 1'b0;
    step();
    chkIdleOuts("rdyLow");
    repeat (5) step();
    chk("rdyLow_hold", DlyLoad, 0);
    fill(0, 8, P_ZERO);
    fill(9, NT - 1, P_ONE);
    DlyRdy = 1'b1;
    runSweep("rdyBack");

    for (int n = 0; n < 20; n++) begin
      randPat();
      pulseRestart("rsRnd");
      runSweep($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nErr);
    $finish;
  end

endmodule
